// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared codes, constants and CRC4 helper for the MTM ALU deserializer
package mtm_alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b100,
      OP_SUB = 3'b101
   } op_t;

   localparam logic [7:0] ERR_DATA = 8'b11001001;
   localparam logic [7:0] ERR_CRC  = 8'b10100101;
   localparam logic [7:0] ERR_OP   = 8'b10010011;
   localparam logic [7:0] CTL_IDLE = 8'hFF;

   localparam logic WORD_DATA = 1'b0;
   localparam logic WORD_CMD  = 1'b1;

   localparam logic [3:0] CRC4_POLY = 4'b0011;

   // Serial CRC4, MSB first, init 0: equivalent to msg * x^4 mod (x^4+x+1)
   function automatic logic [3:0] crc4(input logic [67:0] msg);
      logic [3:0] c;
      logic       fb;
      c = 4'd0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ msg[i];
         c  = {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'd0);
      end
      return c;
   endfunction

endpackage

// File: rtl/mtm_alu_word_rx.sv
// rtl/mtm_alu_word_rx.sv - 11-bit serial word receiver (start, type, 8 payload MSB first, stop)
// Optional MTM_ALU_STOP_CHECK_EN flags a low stop bit on stop_err.
module mtm_alu_word_rx
   import mtm_alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sin,
   output logic [7:0] word_byte,
   output logic       word_type,
   output logic       word_valid,
   output logic       stop_err
);

   typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;

   state_t     state, state_nxt;
   logic [2:0] bit_cnt;
   logic [7:0] shift_q;
   logic       type_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!sin) state_nxt = S_TYPE;
         S_TYPE:  state_nxt = S_DATA;
         S_DATA:  if (bit_cnt == 3'd7) state_nxt = S_STOP;
         S_STOP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= 3'd0;
         shift_q <= 8'd0;
         type_q  <= WORD_DATA;
      end else begin
         case (state)
            S_TYPE: begin
               type_q  <= sin;
               bit_cnt <= 3'd0;
            end
            S_DATA: begin
               shift_q <= {shift_q[6:0], sin};
               bit_cnt <= bit_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

   // Strobe during the stop-bit cycle so the packet logic registers on the same edge
   assign word_valid = (state == S_STOP);
   assign word_byte  = shift_q;
   assign word_type  = type_q;

`ifdef MTM_ALU_STOP_CHECK_EN
   assign stop_err = (state == S_STOP) && !sin;
`else
   assign stop_err = 1'b0;
`endif

endmodule

// File: rtl/mtm_alu_deserializer.sv
// rtl/mtm_alu_deserializer.sv - packet assembly, CRC4/OP check and registered A/B/CTL outputs
module mtm_alu_deserializer
   import mtm_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [7:0]  CTL
);

   logic [7:0]  word_byte;
   logic        word_type;
   logic        word_valid;
   logic        stop_err;
   logic [3:0]  data_cnt;
   logic        overflow;
   logic [63:0] data_sr;
   logic [2:0]  op;
   logic [3:0]  crc_calc;
   logic [7:0]  result;
   logic        pkt_ok;

   mtm_alu_word_rx u_word_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin        (sin),
      .word_byte  (word_byte),
      .word_type  (word_type),
      .word_valid (word_valid),
      .stop_err   (stop_err)
   );

   assign op       = word_byte[6:4];
   assign crc_calc = crc4({data_sr, 1'b1, op});

   always_comb begin
      result = {1'b0, op, word_byte[3:0]};
      pkt_ok = 1'b0;
      if (data_cnt != 4'd8 || overflow)
         result = ERR_DATA;
      else if (crc_calc != word_byte[3:0])
         result = ERR_CRC;
      else if (!(op inside {OP_AND, OP_OR, OP_ADD, OP_SUB}))
         result = ERR_OP;
      else
         pkt_ok = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         CTL      <= CTL_IDLE;
         A        <= 32'd0;
         B        <= 32'd0;
         data_cnt <= 4'd0;
         overflow <= 1'b0;
         data_sr  <= 64'd0;
      end else begin
         CTL <= CTL_IDLE;
         if (stop_err) begin
            CTL      <= ERR_DATA;
            data_cnt <= 4'd0;
            overflow <= 1'b0;
            data_sr  <= 64'd0;
         end else if (word_valid && word_type == WORD_DATA) begin
            // Bytes arrive B MSB first then A, so after 8 words data_sr = {B, A}
            data_sr <= {data_sr[55:0], word_byte};
            if (data_cnt == 4'd8) overflow <= 1'b1;
            if (data_cnt != 4'd9) data_cnt <= data_cnt + 4'd1;
         end else if (word_valid) begin
            CTL      <= result;
            data_cnt <= 4'd0;
            overflow <= 1'b0;
            data_sr  <= 64'd0;
            if (pkt_ok) begin
               B <= data_sr[63:32];
               A <= data_sr[31:0];
            end
         end
      end
   end

endmodule
